// File: rtl/secuenciador_tirar.sv
// Throw/discard counter sequencer: loads the counter with N pulses, then drains it at the tick rate.
// Optional build macro TIRAR_TIMEOUT_EN adds a DESCARGA tick timeout that leads to ERROR.
//
// state    | meaning
// DRENAR   | draining stale counter contents after reset/abort
// IDLE     | ready for a new job
// CARGA    | pulsing iniciar once per cycle, N cycles
// DESCARGA | draining the counter, one tirar_o per decrement
// FIN      | one-cycle job-complete pulse
// ERROR    | timeout, waits for abort_i
module secuenciador_tirar #(
  parameter int CNT_W         = 5,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clk_en_i,
  input  logic             req_valid_i,
  input  logic [CNT_W-1:0] req_cant_i,
  output logic             req_ready_o,
  input  logic             abort_i,
  output logic             cnt_iniciar_o,
  output logic             cnt_decrementar_o,
  input  logic             cnt_done_i,
  output logic             tirar_o,
  output logic [CNT_W-1:0] tirados_o,
  output logic             busy_o,
  output logic             fin_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_DRENAR,
    S_IDLE,
    S_CARGA,
    S_DESCARGA,
    S_FIN,
    S_ERROR
  } state_t;

  if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
    $error("TIMEOUT_TICKS must be at least 1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] tirados_q, tirados_d;

`ifdef TIRAR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tick_q, tick_d;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_DRENAR;
      load_q    <= '0;
      tirados_q <= '0;
`ifdef TIRAR_TIMEOUT_EN
      tick_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      tirados_q <= tirados_d;
`ifdef TIRAR_TIMEOUT_EN
      tick_q    <= tick_d;
`endif
    end
  end

  always_comb begin
    state_d           = state_q;
    load_d            = load_q;
    tirados_d         = tirados_q;
`ifdef TIRAR_TIMEOUT_EN
    tick_d            = tick_q;
`endif
    req_ready_o       = 1'b0;
    cnt_iniciar_o     = 1'b0;
    cnt_decrementar_o = 1'b0;
    busy_o            = 1'b1;
    fin_o             = 1'b0;
    err_o             = 1'b0;
    // done wins over a coincident tick: the counter is already empty
    tirar_o           = (state_q == S_DESCARGA) && clk_en_i && !cnt_done_i;

    case (state_q)
      S_DRENAR: begin
        cnt_decrementar_o = 1'b1;
        if (cnt_done_i) state_d = S_IDLE;
      end
      S_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) begin
          load_d    = req_cant_i;
          tirados_d = '0;
          state_d   = (req_cant_i == '0) ? S_FIN : S_CARGA;
        end
      end
      S_CARGA: begin
        cnt_iniciar_o = 1'b1;
        load_d        = load_q - CNT_W'(1);
        if (load_q == CNT_W'(1)) begin
          state_d = S_DESCARGA;
`ifdef TIRAR_TIMEOUT_EN
          tick_d  = TW'(TIMEOUT_TICKS);
`endif
        end
      end
      S_DESCARGA: begin
        cnt_decrementar_o = 1'b1;
        if (tirar_o && (tirados_q != '1)) tirados_d = tirados_q + CNT_W'(1);
        if (cnt_done_i) state_d = S_FIN;
`ifdef TIRAR_TIMEOUT_EN
        else if (clk_en_i) begin
          if (tick_q == TW'(1)) state_d = S_ERROR;
          else tick_d = tick_q - TW'(1);
        end
`endif
      end
      S_FIN: begin
        fin_o   = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
`ifdef TIRAR_TIMEOUT_EN
        err_o = 1'b1;
`else
        state_d = S_DRENAR;
`endif
      end
      default: state_d = S_DRENAR;
    endcase

    if (abort_i && (state_q == S_CARGA || state_q == S_DESCARGA || state_q == S_ERROR))
      state_d = S_DRENAR;
  end

  assign tirados_o = tirados_q;

endmodule
